// File: rtl/sram_banked_bw.sv
// rtl/sram_banked_bw.sv - banked single-port SRAM with byte enables, 1/2-cycle read path and zero-fill engine
module sram_banked_bw #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 2048,
  parameter int BANKS    = 4,
  parameter int READ_LAT = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CEN,
  input  logic               WEN,
  input  logic [WIDTH/8-1:0] BWEN,
  input  logic [AW-1:0]      A,
  input  logic [WIDTH-1:0]   D,
  output logic [WIDTH-1:0]   Q,
  output logic               VALID,
  input  logic               CLR,
  output logic               BUSY
);
  localparam int NB   = WIDTH / 8;
  localparam int ROWS = DEPTH / BANKS;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BSW  = (BANKS > 1) ? $clog2(BANKS) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]       r_state;
  logic [RW-1:0]    r_cnt;
  logic [31:0]      w_a32;
  logic [BSW-1:0]   w_bank;
  logic [RW-1:0]    w_row;
  logic             w_in_range;
  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_rd_bank [BANKS];
  logic [WIDTH-1:0] w_rd_data;

  assign BUSY       = (r_state == ST_CLEAR);
  assign w_a32      = 32'(A);
  assign w_bank     = BSW'(w_a32 % BANKS);
  assign w_row      = RW'(w_a32 / BANKS);
  assign w_in_range = (w_a32 < 32'(DEPTH));
  assign w_wr       = !CEN && !WEN && !BUSY && w_in_range;
  assign w_rd       = !CEN && WEN && !BUSY;
  assign w_rd_data  = w_in_range ? w_rd_bank[w_bank] : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == RW'(ROWS - 1)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + RW'(1);
          end
        end
        default: begin
          if (CLR) r_state <= ST_CLEAR;
        end
      endcase
    end
  end

  // Every bank clears the same row each cycle, so a full clear takes ROWS cycles.
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] r_mem [ROWS];

    always_ff @(posedge CLK) begin
      if (BUSY) begin
        r_mem[r_cnt] <= '0;
      end else if (w_wr && (w_bank == BSW'(b))) begin
        for (int i = 0; i < NB; i++) begin
          if (!BWEN[i]) r_mem[w_row][8*i +: 8] <= D[8*i +: 8];
        end
      end
    end

    assign w_rd_bank[b] = r_mem[w_row];
  end

  if (READ_LAT == 2) begin : g_lat2
    logic             r_p1_vld;
    logic [WIDTH-1:0] r_p1_data;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        r_p1_vld  <= 1'b0;
        r_p1_data <= '0;
        VALID     <= 1'b0;
        Q         <= '0;
      end else begin
        r_p1_vld <= w_rd;
        if (w_rd) r_p1_data <= w_rd_data;
        VALID <= r_p1_vld;
        if (r_p1_vld) Q <= r_p1_data;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        VALID <= 1'b0;
        Q     <= '0;
      end else begin
        VALID <= w_rd;
        if (w_rd) Q <= w_rd_data;
      end
    end
  end
endmodule

// File: tb/tb_sram_banked_bw.sv
// tb/tb_sram_banked_bw.sv - scoreboard bench: 16x32/4 banks/lat 1 and 8x32/1 bank/lat 2 driven in lockstep
module tb_sram_banked_bw;
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen, wen, clr;
  logic [3:0]  bwen;
  logic [3:0]  a;
  logic [31:0] d;
  logic [31:0] dq0, dq1;
  logic        dv0, dv1, db0, db1;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          bz [2];
  logic [31:0] mem [2][16];
  exp_t        eq0[$], eq1[$];
  logic [31:0] last0 = '0, last1 = '0;
  exp_t        e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_banked_bw #(.WIDTH(32), .DEPTH(16), .BANKS(4), .READ_LAT(1)) u_dut0 (
    .CLK(clk), .RESET(rst), .CEN(cen), .WEN(wen), .BWEN(bwen), .A(a), .D(d),
    .Q(dq0), .VALID(dv0), .CLR(clr), .BUSY(db0)
  );

  sram_banked_bw #(.WIDTH(32), .DEPTH(8), .BANKS(1), .READ_LAT(2)) u_dut1 (
    .CLK(clk), .RESET(rst), .CEN(cen), .WEN(wen), .BWEN(bwen), .A(a[2:0]), .D(d),
    .Q(dq1), .VALID(dv1), .CLR(clr), .BUSY(db1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic flush();
    eq0.delete();
    eq1.delete();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 16; j++) mem[k][j] = '0;
    bz[0] = 4;
    bz[1] = 8;
  endtask

  // Reference: instance k has R rows to clear and read latency L; all addresses fold modulo its depth.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int r  = (k == 0) ? 4 : 8;
      int l  = (k == 0) ? 1 : 2;
      int ad = (k == 0) ? int'(a) : int'(a) % 8;
      if (rst) begin
        bz[k] = r;
      end else if (bz[k] > 0) begin
        bz[k]--;
      end else begin
        if (!cen && !wen) begin
          for (int i = 0; i < 4; i++)
            if (!bwen[i]) mem[k][ad][8*i +: 8] = d[8*i +: 8];
        end else if (!cen && wen) begin
          exp_t e;
          e.data = mem[k][ad];
          e.due  = cyc + l - 1;
          if (k == 0) eq0.push_back(e);
          else        eq1.push_back(e);
        end
        if (clr) begin
          bz[k] = r;
          for (int j = 0; j < 16; j++) mem[k][j] = '0;
        end
      end
    end
  endtask

  task automatic step(input logic c, input logic w, input logic [3:0] be,
                      input logic [3:0] ad, input logic [31:0] dd, input logic cl);
    cen = c; wen = w; bwen = be; a = ad; d = dd; clr = cl;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 4'hF, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] ad, input logic [31:0] dd, input logic [3:0] be);
    step(1'b0, 1'b0, be, ad, dd, 1'b0);
  endtask

  task automatic rd(input logic [3:0] ad);
    step(1'b0, 1'b1, 4'hF, ad, 32'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_q0", dq0, 32'h0);
      chk("rst_v0", {31'h0, dv0}, 32'h0);
      chk("rst_busy0", {31'h0, db0}, 32'h1);
      last0 = '0;
    end else begin
      chk("busy0", {31'h0, db0}, {31'h0, bz[0] > 0});
      if (dv0) begin
        if (eq0.size() == 0) begin
          chk("spurious_valid0", {31'h0, dv0}, 32'h0);
        end else begin
          e0 = eq0.pop_front();
          chk("rdata0", dq0, e0.data);
          chk("latency0", cyc, e0.due);
          last0 = e0.data;
        end
      end else begin
        chk("hold0", dq0, last0);
        if (eq0.size() > 0 && eq0[0].due < cyc) begin
          chk("missing_valid0", cyc, eq0[0].due);
          void'(eq0.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_q1", dq1, 32'h0);
      chk("rst_v1", {31'h0, dv1}, 32'h0);
      chk("rst_busy1", {31'h0, db1}, 32'h1);
      last1 = '0;
    end else begin
      chk("busy1", {31'h0, db1}, {31'h0, bz[1] > 0});
      if (dv1) begin
        if (eq1.size() == 0) begin
          chk("spurious_valid1", {31'h0, dv1}, 32'h0);
        end else begin
          e1 = eq1.pop_front();
          chk("rdata1", dq1, e1.data);
          chk("latency1", cyc, e1.due);
          last1 = e1.data;
        end
      end else begin
        chk("hold1", dq1, last1);
        if (eq1.size() > 0 && eq1[0].due < cyc) begin
          chk("missing_valid1", cyc, eq1[0].due);
          void'(eq1.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    cen = 1'b1; wen = 1'b1; bwen = 4'hF; a = '0; d = '0; clr = 1'b0;
    flush();
    idle(3);
    rst = 1'b0;
    idle(8);
    for (int i = 0; i < 16; i++) rd(4'(i));

    wr(4'd5, 32'hAABBCCDD, 4'b0000);
    wr(4'd5, 32'h11223344, 4'b1010);
    rd(4'd5);
    wr(4'd6, 32'h55667788, 4'b1111);
    rd(4'd6);
    idle(2);
    for (int i = 0; i < 4; i++) rd(4'(i));
    idle(2);

    for (int i = 0; i < 16; i++) wr(4'(i), 32'hFFFFFFFF, 4'b0000);
    rd(4'd9);
    step(1'b0, 1'b0, 4'b0000, 4'd3, 32'h12345678, 1'b1);
    wr(4'd7, 32'hCAFEF00D, 4'b0000);
    step(1'b0, 1'b1, 4'hF, 4'd2, 32'h0, 1'b1);
    idle(7);
    for (int i = 0; i < 16; i++) rd(4'(i));

    for (int n = 0; n < 80; n++) begin
      int op = $urandom_range(0, 9);
      logic cl = ($urandom_range(0, 15) == 0);
      logic [3:0] ad = 4'($urandom_range(0, 15));
      if (op < 4)      step(1'b0, 1'b0, 4'($urandom_range(0, 15)), ad, $urandom, cl);
      else if (op < 8) step(1'b0, 1'b1, 4'hF, ad, 32'h0, cl);
      else             step(1'b1, 1'b1, 4'hF, ad, 32'h0, cl);
    end
    idle(8);

    wr(4'd7, 32'hDEADBEEF, 4'b0000);
    rd(4'd7);
    rd(4'd5);
    step(1'b0, 1'b1, 4'hF, 4'd7, 32'h0, 1'b1);
    rst = 1'b1;
    flush();
    idle(2);
    rst = 1'b0;
    idle(9);
    rd(4'd7);
    rd(4'd15);
    idle(4);

    chk("drain0", eq0.size(), 32'h0);
    chk("drain1", eq1.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_banked_bw.md
# sram_banked_bw

Parametrised single-port SRAM model. It is the next-generation storage block for the k-furthest-neighbors datapath, replacing the fixed 2048x32 memories. It adds configurable width, depth and bank count, per-byte write enables, a 1- or 2-stage registered read path with a valid strobe, and a hardware zero-fill engine that clears all banks in parallel after reset or on request. Feature and distance buffers instantiate it directly.

## Interface
Parameters:
- WIDTH, 32: data width in bits; multiple of 8.
- DEPTH, 2048: number of words; multiple of BANKS.
- BANKS, 4: power of 2, ≥1. Word address A maps to bank A[log2(BANKS)-1:0], row A >> log2(BANKS).
- READ_LAT, 1: read latency in cycles; legal values 1 or 2.
- AW, $clog2(DEPTH): address width (derived).

Ports (clock and reset first):
- CLK, input, 1: clock, rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- CEN, input, 1: chip enable, active-low.
- WEN, input, 1: 0 = write, 1 = read; only meaningful when CEN=0.
- BWEN, input, WIDTH/8: byte write enable, active-low. Bit i gates D[8i+7:8i].
- A, input, AW: word address.
- D, input, WIDTH: write data.
- Q, output, WIDTH: registered read data; holds its value between reads.
- VALID, output, 1: one-cycle pulse when Q carries fresh read data.
- CLR, input, 1: zero-fill request; sampled only in IDLE.
- BUSY, output, 1: 1 while zero-fill is active; all accesses are ignored.

## Operation
- FSM states:
  - CLEAR: asserted asynchronously by RESET, and held while RESET=1.
    - Row counter starts at 0.
    - Each cycle, writes 0 to row `cnt` of every bank simultaneously, then increments `cnt`.
    - When `cnt` = DEPTH/BANKS-1 that row is written, and the FSM moves to IDLE on the same edge.
  - IDLE: CLR=1 moves to CLEAR on the next edge.
- BUSY = (state == CLEAR), combinational from state.
- An access is accepted when CEN=0 and BUSY=0.
- Accepted write: for each byte i with BWEN[i]=0, that byte at A is updated from D at the edge. Other bytes keep their value. All-ones BWEN is a legal no-op.
- Accepted read: data for A enters the read pipeline.
- CLR=1 in IDLE in the same cycle as an access: the access executes, and CLEAR starts on the next cycle.
- Read requests already in flight when CLEAR begins complete normally and return the pre-clear data.
- Accesses presented while BUSY=1 are dropped silently:
  - no memory change;
  - no VALID pulse;
  - Q unchanged.
- CLR while BUSY=1 is ignored; the clear does not restart.
- Out-of-range A (A ≥ DEPTH when DEPTH is not a power of 2): writes are dropped; reads return 0 with VALID.

## Timing
- Reset values:
  - Q = 0, VALID = 0, BUSY = 1;
  - state = CLEAR, cnt = 0;
  - read pipeline stages cleared.
- RESET asserted mid-clear or mid-read: aborts everything and restarts the clear from row 0. In-flight reads produce no VALID.
- Clear duration: BUSY drops DEPTH/BANKS cycles after the first rising edge with RESET=0, or after the edge that samples CLR.
- Read latency, with the read sampled at edge t:
  - READ_LAT=1: Q and VALID update at edge t.
  - READ_LAT=2: Q and VALID update at edge t+1.
  - VALID is high for exactly one cycle per read.
- Back-to-back reads: one accepted per cycle; Q and VALID stream at the same rate.
- Write then read of the same address on the next cycle: returns the newly written bytes, with no bypass hazard.
- Write and read cannot coincide (single port).
- Only a read updates Q. Later writes to the same address do not alter Q.

## Test plan
Bench configuration: WIDTH=32, DEPTH=16, BANKS=4, unless stated otherwise.

1. Reset then release:
   - BUSY=1 for exactly 4 cycles after release, then 0.
   - Reads of A=0..15 all return Q=0x00000000 with VALID pulses.
   - Q=0 and VALID=0 throughout reset.
2. Byte-masked write:
   - Write D=0xAABBCCDD to A=5 with BWEN=4'b0000, then write D=0x11223344 with BWEN=4'b1010.
   - Read A=5 returns 0xAA22CC44.
3. Read latency:
   - READ_LAT=1: read A=5 at edge t; VALID=1 and Q valid after edge t.
   - READ_LAT=2: same read; VALID and Q valid one cycle later.
   - 4 back-to-back reads A=0..3 give 4 consecutive VALID cycles in order.
4. CLR with a collision:
   - Fill all addresses with 0xFFFFFFFF.
   - Pulse CLR in the same cycle as a write of 0x12345678 to A=3.
   - A write attempted to A=7 during BUSY is dropped.
   - Afterwards every address reads 0; BUSY lasted 4 cycles.
5. RESET mid-clear:
   - Assert RESET at clear cycle 2 with a read in flight.
   - No VALID is seen, Q=0, and the clear restarts: BUSY lasts 4 full cycles after release.
6. BANKS=1, DEPTH=8:
   - Clear takes 8 cycles.
   - Writing A=7 with 0xDEADBEEF and reading it back gives 0xDEADBEEF with correct latency.
